// File: rtl/ifetch.sv
// Instruction fetch stage: word-indexed PC, one-cycle fetch-to-decode latency,
// redirect over stall over advance, optional EBREAK halt (macro FETCH_HALT_EN).
//
// Parameters:
//   n           data/address width (n >= 32)
//   RESET_PC    word index fetched first after reset
// Ports:
//   clock       single clock, rising edge
//   reset       asynchronous, active-high
//   stall       decode cannot accept a new instruction
//   redirect    branch/jump replaces the PC
//   redirect_pc target word index, sampled only when redirect is high
//   imem_addr   word index presented to instruction memory (= PC)
//   imem_instr  instruction returned combinationally by instruction memory
//   if_instr    fetched instruction to decode
//   if_pc       word index of if_instr
//   if_valid    if_instr/if_pc are meaningful
//   halted      fetch stopped on EBREAK (tied 0 unless FETCH_HALT_EN)
module ifetch #(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    output logic [n-1:0] imem_addr,
    input  logic [n-1:0] imem_instr,
    output logic [n-1:0] if_instr,
    output logic [n-1:0] if_pc,
    output logic         if_valid,
    output logic         halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    state_t       state;
    logic [n-1:0] pc;
    logic [n-1:0] pc_inc;
    logic         in_halt;
    logic         is_halt;
    logic         do_redirect;
    logic         do_hold;
    logic         do_fetch;

    // PC+1 wraps modulo 2^n by construction.
    assign pc_inc    = pc + ONE;
    assign imem_addr = pc;
    assign in_halt   = (state == HALT);

`ifdef FETCH_HALT_EN
    localparam logic [n-1:0] EBREAK = n'(32'h0010_0073);
    logic halt_q;

    assign is_halt = (imem_instr == EBREAK);
    assign halted  = halt_q;
`else
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    // One-hot action: redirect beats everything, HALT or stall hold,
    // otherwise advance.
    always_comb begin
        do_redirect = 1'b0;
        do_hold     = 1'b0;
        do_fetch    = 1'b0;
        if (redirect) begin
            do_redirect = 1'b1;
        end else if (in_halt || stall) begin
            do_hold = 1'b1;
        end else begin
            do_fetch = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            if_instr <= '0;
            if_pc    <= '0;
            if_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            halt_q   <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                do_redirect: begin
                    // The word on imem this cycle is dropped; the target
                    // is captured on the following edge.
                    pc       <= redirect_pc;
                    if_valid <= 1'b0;
                    state    <= RUN;
`ifdef FETCH_HALT_EN
                    halt_q   <= 1'b0;
`endif
                end
                do_hold: begin
                    if (in_halt) begin
                        if_valid <= 1'b0;
                    end
                end
                do_fetch: begin
                    if_instr <= imem_instr;
                    if_pc    <= pc;
                    if_valid <= 1'b1;
                    if (is_halt) begin
                        // EBREAK is delivered once; PC parks on it.
                        state  <= HALT;
`ifdef FETCH_HALT_EN
                        halt_q <= 1'b1;
`endif
                    end else begin
                        pc <= pc_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized
// stall/redirect traffic against a behavioural fetch model.
module tb_ifetch;

    localparam int          N      = 32;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;

    logic [31:0] mem [64];
    logic [31:0] abcd [4];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_valid;
    logic        m_halt;

    ifetch #(.n(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    assign imem_instr = mem[imem_addr[5:0]];

    task automatic model_reset;
        m_pc    = 32'd0;
        m_instr = 32'd0;
        m_ifpc  = 32'd0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic step(input logic st, input logic rd,
                        input logic [31:0] rpc);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clock);
        if (rd) begin
            m_pc    = rpc;
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem[m_pc[5:0]];
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            if (HALT_EN && m_instr == EBREAK) m_halt = 1'b1;
            else m_pc = m_pc + 32'd1;
        end
        #1;
    endtask

    task automatic do_reset;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        reset       = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        stall    = 1'b0;
        redirect = 1'b0;
        reset    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (imem_addr !== 32'd0 || if_valid !== 1'b0 || halted !== 1'b0
            || if_pc !== 32'd0 || if_instr !== 32'd0) begin
            bad++;
            $display("FAIL reset: addr=%h valid=%b halted=%b pc=%h instr=%h want all 0",
                     imem_addr, if_valid, halted, if_pc, if_instr);
        end
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_straight;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0);
            total++;
            if (if_pc !== 32'(i) || if_instr !== abcd[i] || if_valid !== 1'b1
                || imem_addr !== 32'(i + 1)) begin
                bad++;
                $display("FAIL straight[%0d]: pc=%h instr=%h valid=%b addr=%h want %h %h 1 %h",
                         i, if_pc, if_instr, if_valid, imem_addr, i, abcd[i], i + 1);
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0);
            total++;
            if (if_pc !== 32'd1 || if_instr !== abcd[1] || imem_addr !== 32'd2
                || if_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall[%0d]: pc=%h instr=%h addr=%h valid=%b want 1 %h 2 1",
                         i, if_pc, if_instr, imem_addr, if_valid, abcd[1]);
            end
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd2 || if_instr !== abcd[2] || if_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: pc=%h instr=%h valid=%b want 2 %h 1",
                     if_pc, if_instr, if_valid, abcd[2]);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd9);
        total++;
        if (if_valid !== 1'b0 || imem_addr !== 32'd9 || if_pc !== 32'd1
            || if_instr !== abcd[1]) begin
            bad++;
            $display("FAIL redirect: valid=%b addr=%h pc=%h instr=%h want 0 9 1 %h",
                     if_valid, imem_addr, if_pc, if_instr, abcd[1]);
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd9 || if_valid !== 1'b1 || if_instr !== mem[9]) begin
            bad++;
            $display("FAIL redirect_target: pc=%h valid=%b instr=%h want 9 1 %h",
                     if_pc, if_valid, if_instr, mem[9]);
        end
    endtask

    task automatic test_wrap;
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        total++;
        if (imem_addr !== 32'hFFFF_FFFF || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrap_redirect: addr=%h valid=%b want ffffffff 0",
                     imem_addr, if_valid);
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'hFFFF_FFFF || if_instr !== mem[63] || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL wrap_top: pc=%h instr=%h addr=%h want ffffffff %h 0",
                     if_pc, if_instr, imem_addr, mem[63]);
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd0 || if_instr !== mem[0] || if_valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_zero: pc=%h instr=%h valid=%b want 0 %h 1",
                     if_pc, if_instr, if_valid, mem[0]);
        end
    endtask

`ifdef FETCH_HALT_EN
    task automatic test_halt;
        mem[2] = EBREAK;
        do_reset();
        repeat (3) step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd2 || if_instr !== EBREAK || if_valid !== 1'b1
            || halted !== 1'b1 || imem_addr !== 32'd2) begin
            bad++;
            $display("FAIL halt_enter: pc=%h instr=%h valid=%b halted=%b addr=%h",
                     if_pc, if_instr, if_valid, halted, imem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom_range(1)), 1'b0, 32'd0);
            total++;
            if (if_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'd2) begin
                bad++;
                $display("FAIL halt_hold[%0d]: valid=%b halted=%b addr=%h want 0 1 2",
                         i, if_valid, halted, imem_addr);
            end
        end
        step(1'b1, 1'b1, 32'd0);
        total++;
        if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL halt_resume: halted=%b valid=%b addr=%h want 0 0 0",
                     halted, if_valid, imem_addr);
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd0 || if_valid !== 1'b1 || if_instr !== abcd[0]) begin
            bad++;
            $display("FAIL halt_refetch: pc=%h valid=%b instr=%h want 0 1 %h",
                     if_pc, if_valid, if_instr, abcd[0]);
        end
        mem[2] = abcd[2];
    endtask
`else
    task automatic test_ebreak_plain;
        mem[2] = EBREAK;
        do_reset();
        repeat (3) step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd2 || if_instr !== EBREAK || halted !== 1'b0) begin
            bad++;
            $display("FAIL ebreak_plain: pc=%h instr=%h halted=%b want 2 %h 0",
                     if_pc, if_instr, halted, EBREAK);
        end
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd3 || if_valid !== 1'b1 || halted !== 1'b0) begin
            bad++;
            $display("FAIL ebreak_next: pc=%h valid=%b halted=%b want 3 1 0",
                     if_pc, if_valid, halted);
        end
        mem[2] = abcd[2];
    endtask
`endif

    task automatic test_async_reset;
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
`ifdef FETCH_HALT_EN
        mem[5] = EBREAK;
        step(1'b0, 1'b1, 32'd5);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        mem[5] = 32'h5555_0005;
`endif
        // Mid-cycle assertion, away from any edge, with stall still high.
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (imem_addr !== 32'd0 || if_valid !== 1'b0 || halted !== 1'b0
            || if_pc !== 32'd0 || if_instr !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: addr=%h valid=%b halted=%b pc=%h instr=%h want all 0",
                     imem_addr, if_valid, halted, if_pc, if_instr);
        end
        model_reset();
        stall    = 1'b0;
        redirect = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 32'd0);
        total++;
        if (if_pc !== 32'd0 || if_instr !== abcd[0] || if_valid !== 1'b1) begin
            bad++;
            $display("FAIL async_restart: pc=%h instr=%h valid=%b want 0 %h 1",
                     if_pc, if_instr, if_valid, abcd[0]);
        end
    endtask

    task automatic test_random;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
`ifdef FETCH_HALT_EN
        mem[40] = EBREAK;
`endif
        do_reset();
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(9) < 3);
            rd  = ($urandom_range(11) == 0);
            case ($urandom_range(3))
                0:       rpc = 32'hFFFF_FFFE + 32'($urandom_range(1));
                1:       rpc = $urandom;
                default: rpc = 32'($urandom_range(63));
            endcase
            step(st, rd, rpc);
            total++;
            if (imem_addr !== m_pc || if_valid !== m_valid || halted !== m_halt
                || if_pc !== m_ifpc || if_instr !== m_instr) begin
                bad++;
                $display("FAIL random[%0d]: addr=%h/%h valid=%b/%b halted=%b/%b pc=%h/%h instr=%h/%h",
                         i, imem_addr, m_pc, if_valid, m_valid, halted, m_halt,
                         if_pc, m_ifpc, if_instr, m_instr);
            end
        end
`ifdef FETCH_HALT_EN
        mem[40] = 32'h4040_0040;
`endif
    endtask

    initial begin
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        reset       = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == EBREAK) mem[i] = ~EBREAK;
        end
        abcd[0] = 32'hA000_000A;
        abcd[1] = 32'hB000_000B;
        abcd[2] = 32'hC000_000C;
        abcd[3] = 32'hD000_000D;
        for (int i = 0; i < 4; i++) mem[i] = abcd[i];

        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_wrap();
`ifdef FETCH_HALT_EN
        test_halt();
`else
        test_ebreak_plain();
`endif
        test_async_reset();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
